// File: rtl/wb_tlb_op_unit_pkg.sv
// Shared TLB definitions: entry layout, op codes, CSR field positions and FSM states.
package tlb_pkg;

    localparam int unsigned TLB_ENTRY_W = 89;

    // Entry layout, MSB first: {e, vppn[18:0], ps[5:0], g, asid[9:0], page0, page1}
    localparam int unsigned E_BIT     = 88;
    localparam int unsigned VPPN_LSB  = 69;
    localparam int unsigned PS_LSB    = 63;
    localparam int unsigned G_BIT     = 62;
    localparam int unsigned ASID_LSB  = 52;
    localparam int unsigned PAGE0_LSB = 26;
    localparam int unsigned PAGE1_LSB = 0;
    localparam int unsigned PAGE_W    = 26;

    // Within a page: {ppn[19:0], plv[1:0], mat[1:0], d, v}
    localparam int unsigned PPN_OFS = 6;
    localparam int unsigned PLV_OFS = 4;
    localparam int unsigned MAT_OFS = 2;
    localparam int unsigned D_OFS   = 1;
    localparam int unsigned V_OFS   = 0;

    localparam logic [2:0] TLB_OP_SRCH = 3'd1;
    localparam logic [2:0] TLB_OP_RD   = 3'd2;
    localparam logic [2:0] TLB_OP_WR   = 3'd3;
    localparam logic [2:0] TLB_OP_FILL = 3'd4;
    localparam logic [2:0] TLB_OP_INV  = 3'd5;

    localparam int unsigned CSR_IDX_NE     = 31;
    localparam int unsigned CSR_IDX_PS_LSB = 24;
    localparam int unsigned CSR_ELO_G      = 6;

    localparam logic [5:0] ECODE_TLBR = 6'h3f;
    localparam logic [5:0] PS_4M      = 6'd21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } tlb_state_e;

    // TLBELO image of one page: {4'b0, ppn, 1'b0, g, mat, plv, d, v}
    function automatic logic [31:0] page_to_elo(input logic [PAGE_W-1:0] page, input logic g);
        return {4'b0, page[PPN_OFS +: 20], 1'b0, g, page[MAT_OFS +: 2],
                page[PLV_OFS +: 2], page[D_OFS], page[V_OFS]};
    endfunction

endpackage

// File: rtl/wb_tlb_op_unit_inv_match.sv
// Combinational INVTLB match of one TLB entry against the latched op/asid/va.
module tlb_inv_match
    import tlb_pkg::*;
(
    input  logic        entry_g,
    input  logic [9:0]  entry_asid,
    input  logic [5:0]  entry_ps,
    input  logic [18:0] entry_vppn,
    input  logic [4:0]  op,
    input  logic [9:0]  asid,
    input  logic [18:0] va_vppn,
    output logic        hit
);

    logic asid_eq;
    logic vppn_eq;

    always_comb begin
        asid_eq = (entry_asid == asid);
        // 4MB pages ignore the low VPPN bits covered by the page offset
        if (entry_ps == PS_4M) begin
            vppn_eq = (entry_vppn[18:9] == va_vppn[18:9]);
        end else begin
            vppn_eq = (entry_vppn == va_vppn);
        end
        case (op)
            5'd0, 5'd1: hit = 1'b1;
            5'd2:       hit = entry_g;
            5'd3:       hit = ~entry_g;
            5'd4:       hit = ~entry_g & asid_eq;
            5'd5:       hit = ~entry_g & asid_eq & vppn_eq;
            5'd6:       hit = (entry_g | asid_eq) & vppn_eq;
            default:    hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_tlb_op_unit.sv
// WB-stage TLB maintenance engine: single-cycle SRCH/RD/WR/FILL, multi-cycle INVTLB sweep.
// Define TLB_FILL_LFSR_EN to pick the FILL index from an 8-bit LFSR instead of round-robin.
module wb_tlb_op_unit
    import tlb_pkg::*;
#(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDX_W  = $clog2(TLBNUM)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [2:0]             op_code,
    input  logic [4:0]             inv_op,
    input  logic [9:0]             inv_asid,
    input  logic [31:0]            inv_va,
    output logic                   op_done,
    output logic                   op_ine,
    input  logic [31:0]            csr_idx,
    input  logic [31:0]            csr_ehi,
    input  logic [31:0]            csr_elo0,
    input  logic [31:0]            csr_elo1,
    input  logic [31:0]            csr_asid,
    input  logic [5:0]             csr_ecode,
    input  logic                   s_found,
    input  logic [IDX_W-1:0]       s_index,
    output logic [IDX_W-1:0]       r_index,
    input  logic [TLB_ENTRY_W-1:0] r_entry,
    output logic                   we,
    output logic [IDX_W-1:0]       w_index,
    output logic [TLB_ENTRY_W-1:0] w_entry,
    output logic [3:0]             csr_tlb_we,
    output logic [31:0]            csr_idx_wv,
    output logic [31:0]            csr_ehi_wv,
    output logic [31:0]            csr_elo0_wv,
    output logic [31:0]            csr_elo1_wv,
    output logic [31:0]            csr_asid_wv
);

    tlb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       sweep_q, sweep_d;
    logic [4:0]             inv_op_q, inv_op_d;
    logic [9:0]             inv_asid_q, inv_asid_d;
    logic [18:0]            inv_vppn_q, inv_vppn_d;
    logic [IDX_W-1:0]       fill_idx;
    logic                   fill_step;
    logic                   inv_hit;
    logic [TLB_ENTRY_W-1:0] wr_entry;
    logic                   unused_bits;

`ifdef TLB_FILL_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        fill_idx = lfsr_q[IDX_W-1:0];
        lfsr_d   = lfsr_q;
        if (fill_step) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [IDX_W-1:0] fill_q, fill_d;

    always_comb begin
        fill_idx = fill_q;
        fill_d   = fill_q;
        if (fill_step) begin
            fill_d = fill_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end
`endif

    assign op_ready    = (state_q == ST_IDLE);
    assign unused_bits = ^{csr_ehi[12:0], csr_elo0[31:28], csr_elo0[7],
                           csr_elo1[31:28], csr_elo1[7], inv_va[12:0]};

    tlb_inv_match u_match (
        .entry_g    (r_entry[G_BIT]),
        .entry_asid (r_entry[ASID_LSB +: 10]),
        .entry_ps   (r_entry[PS_LSB +: 6]),
        .entry_vppn (r_entry[VPPN_LSB +: 19]),
        .op         (inv_op_q),
        .asid       (inv_asid_q),
        .va_vppn    (inv_vppn_q),
        .hit        (inv_hit)
    );

    // Entry image shared by TLBWR and TLBFILL
    always_comb begin
        wr_entry                          = '0;
        wr_entry[E_BIT]                   = (csr_ecode == ECODE_TLBR) | ~csr_idx[CSR_IDX_NE];
        wr_entry[VPPN_LSB +: 19]          = csr_ehi[31:13];
        wr_entry[PS_LSB +: 6]             = csr_idx[CSR_IDX_PS_LSB +: 6];
        wr_entry[G_BIT]                   = csr_elo0[CSR_ELO_G] & csr_elo1[CSR_ELO_G];
        wr_entry[ASID_LSB +: 10]          = csr_asid[9:0];
        wr_entry[PAGE0_LSB +: PAGE_W]     = {csr_elo0[27:8], csr_elo0[3:2], csr_elo0[5:4],
                                             csr_elo0[1], csr_elo0[0]};
        wr_entry[PAGE1_LSB +: PAGE_W]     = {csr_elo1[27:8], csr_elo1[3:2], csr_elo1[5:4],
                                             csr_elo1[1], csr_elo1[0]};
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        inv_op_d    = inv_op_q;
        inv_asid_d  = inv_asid_q;
        inv_vppn_d  = inv_vppn_q;
        fill_step   = 1'b0;
        op_done     = 1'b0;
        op_ine      = 1'b0;
        r_index     = '0;
        we          = 1'b0;
        w_index     = '0;
        w_entry     = '0;
        csr_tlb_we  = '0;
        csr_idx_wv  = '0;
        csr_ehi_wv  = '0;
        csr_elo0_wv = '0;
        csr_elo1_wv = '0;
        csr_asid_wv = '0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        TLB_OP_SRCH: begin
                            op_done                 = 1'b1;
                            csr_tlb_we              = 4'b0001;
                            csr_idx_wv              = csr_idx;
                            csr_idx_wv[CSR_IDX_NE]  = ~s_found;
                            if (s_found) begin
                                csr_idx_wv[IDX_W-1:0] = s_index;
                            end
                        end
                        TLB_OP_RD: begin
                            op_done    = 1'b1;
                            r_index    = csr_idx[IDX_W-1:0];
                            csr_tlb_we = 4'b1111;
                            csr_idx_wv = csr_idx;
                            csr_asid_wv = {csr_asid[31:10], 10'b0};
                            if (r_entry[E_BIT]) begin
                                csr_idx_wv[CSR_IDX_NE]              = 1'b0;
                                csr_idx_wv[CSR_IDX_PS_LSB +: 6]     = r_entry[PS_LSB +: 6];
                                csr_ehi_wv  = {r_entry[VPPN_LSB +: 19], 13'b0};
                                csr_elo0_wv = page_to_elo(r_entry[PAGE0_LSB +: PAGE_W], r_entry[G_BIT]);
                                csr_elo1_wv = page_to_elo(r_entry[PAGE1_LSB +: PAGE_W], r_entry[G_BIT]);
                                csr_asid_wv[9:0] = r_entry[ASID_LSB +: 10];
                            end else begin
                                csr_idx_wv[CSR_IDX_NE] = 1'b1;
                            end
                        end
                        TLB_OP_WR, TLB_OP_FILL: begin
                            op_done   = 1'b1;
                            we        = 1'b1;
                            w_entry   = wr_entry;
                            fill_step = (op_code == TLB_OP_FILL);
                            w_index   = (op_code == TLB_OP_FILL) ? fill_idx : csr_idx[IDX_W-1:0];
                        end
                        TLB_OP_INV: begin
                            if (inv_op > 5'd6) begin
                                op_done = 1'b1;
                                op_ine  = 1'b1;
                            end else begin
                                inv_op_d   = inv_op;
                                inv_asid_d = inv_asid;
                                inv_vppn_d = inv_va[31:13];
                                sweep_d    = '0;
                                state_d    = ST_SWEEP;
                            end
                        end
                        default: op_done = 1'b1;
                    endcase
                end
            end
            ST_SWEEP: begin
                r_index = sweep_q;
                if (inv_hit) begin
                    we             = 1'b1;
                    w_index        = sweep_q;
                    w_entry        = r_entry;
                    w_entry[E_BIT] = 1'b0;
                end
                if (sweep_q == IDX_W'(TLBNUM - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    sweep_d = sweep_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                op_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            sweep_q    <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            inv_op_q   <= inv_op_d;
            inv_asid_q <= inv_asid_d;
            inv_vppn_q <= inv_vppn_d;
        end
    end

endmodule

// File: tb/tb_wb_tlb_op_unit.sv
// Scoreboard bench for wb_tlb_op_unit with a behavioural 16-entry TLB array.
module tb_wb_tlb_op_unit;
    import tlb_pkg::*;

    localparam int unsigned N = 16;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } ent_t;

    typedef struct {
        string       tag;
        logic        done;
        logic        ine;
        logic        we;
        logic [3:0]  idx;
        logic [88:0] ent;
        logic [3:0]  cwe;
        logic [31:0] idxv;
        logic [31:0] ehiv;
        logic [31:0] elo0v;
        logic [31:0] elo1v;
        logic [31:0] asidv;
    } ev_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [31:0] inv_va;
    logic        op_done;
    logic        op_ine;
    logic [31:0] csr_idx, csr_ehi, csr_elo0, csr_elo1, csr_asid;
    logic [5:0]  csr_ecode;
    logic        s_found;
    logic [3:0]  s_index;
    logic [3:0]  r_index;
    logic [88:0] r_entry;
    logic        we;
    logic [3:0]  w_index;
    logic [88:0] w_entry;
    logic [3:0]  csr_tlb_we;
    logic [31:0] csr_idx_wv, csr_ehi_wv, csr_elo0_wv, csr_elo1_wv, csr_asid_wv;

    logic [88:0] tlb [N];
    logic [88:0] orig [N];
    ev_t         exp_q[$];
    ev_t         mon_ev;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign r_entry = tlb[r_index];

    wb_tlb_op_unit #(.TLBNUM(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .inv_op      (inv_op),
        .inv_asid    (inv_asid),
        .inv_va      (inv_va),
        .op_done     (op_done),
        .op_ine      (op_ine),
        .csr_idx     (csr_idx),
        .csr_ehi     (csr_ehi),
        .csr_elo0    (csr_elo0),
        .csr_elo1    (csr_elo1),
        .csr_asid    (csr_asid),
        .csr_ecode   (csr_ecode),
        .s_found     (s_found),
        .s_index     (s_index),
        .r_index     (r_index),
        .r_entry     (r_entry),
        .we          (we),
        .w_index     (w_index),
        .w_entry     (w_entry),
        .csr_tlb_we  (csr_tlb_we),
        .csr_idx_wv  (csr_idx_wv),
        .csr_ehi_wv  (csr_ehi_wv),
        .csr_elo0_wv (csr_elo0_wv),
        .csr_elo1_wv (csr_elo1_wv),
        .csr_asid_wv (csr_asid_wv)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t ev0(input string tag);
        ev_t e;
        e.tag = tag; e.done = 1'b1; e.ine = 1'b0; e.we = 1'b0; e.idx = '0; e.ent = '0;
        e.cwe = '0; e.idxv = '0; e.ehiv = '0; e.elo0v = '0; e.elo1v = '0; e.asidv = '0;
        return e;
    endfunction

    // Entry written by WR/FILL from the CSR values used throughout
    function automatic logic [88:0] wr_ent(input logic e, input logic [5:0] ps);
        ent_t t;
        t = '0;
        t.e = e; t.vppn = 19'h00123; t.ps = ps; t.g = 1'b1; t.asid = 10'h005;
        t.ppn0 = 20'h1; t.d0 = 1'b1; t.v0 = 1'b1;
        t.ppn1 = 20'h2; t.v1 = 1'b1;
        return t;
    endfunction

    // Monitor: pops on every visible DUT response and mirrors writes into the array
    always @(negedge clk) begin
        if (resetn && (op_done || we)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got done=%0b we=%0b idx=%0d expected none", op_done, we, w_index);
            end else begin
                mon_ev = exp_q.pop_front();
                check({mon_ev.tag, "_done"}, 128'(op_done), 128'(mon_ev.done));
                check({mon_ev.tag, "_ine"}, 128'(op_ine), 128'(mon_ev.ine));
                check({mon_ev.tag, "_we"}, 128'(we), 128'(mon_ev.we));
                check({mon_ev.tag, "_csr_we"}, 128'(csr_tlb_we), 128'(mon_ev.cwe));
                if (mon_ev.we) begin
                    check({mon_ev.tag, "_w_index"}, 128'(w_index), 128'(mon_ev.idx));
                    check({mon_ev.tag, "_w_entry"}, 128'(w_entry), 128'(mon_ev.ent));
                end
                if (mon_ev.cwe[0]) check({mon_ev.tag, "_idx_wv"}, 128'(csr_idx_wv), 128'(mon_ev.idxv));
                if (mon_ev.cwe[1]) check({mon_ev.tag, "_ehi_wv"}, 128'(csr_ehi_wv), 128'(mon_ev.ehiv));
                if (mon_ev.cwe[2]) begin
                    check({mon_ev.tag, "_elo0_wv"}, 128'(csr_elo0_wv), 128'(mon_ev.elo0v));
                    check({mon_ev.tag, "_elo1_wv"}, 128'(csr_elo1_wv), 128'(mon_ev.elo1v));
                end
                if (mon_ev.cwe[3]) check({mon_ev.tag, "_asid_wv"}, 128'(csr_asid_wv), 128'(mon_ev.asidv));
            end
            if (we) tlb[w_index] = w_entry;
        end
    end

    task automatic issue(input logic [2:0] code);
        @(posedge clk);
        #1;
        op_code  = code;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge clk);
            if (op_done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done_timeout: got no op_done expected op_done within %0d cycles", max_cycles);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t  e;
        ent_t t;
        logic [7:0] lf;

        resetn = 1'b0; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0; inv_va = '0;
        csr_idx = '0; csr_ehi = '0; csr_elo0 = '0; csr_elo1 = '0; csr_asid = '0; csr_ecode = '0;
        s_found = 1'b0; s_index = '0;
        for (int i = 0; i < N; i++) tlb[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_op_ready", 128'(op_ready), 128'(1));
        check("reset_outputs", 128'({op_done, op_ine, we, csr_tlb_we}), 128'(0));
        resetn = 1'b1;

        // SRCH hit and miss
        csr_ehi = 32'h0024_6000; csr_idx = 32'h8000_0000; s_found = 1'b1; s_index = 4'd5;
        e = ev0("srch_hit"); e.cwe = 4'b0001; e.idxv = 32'h0000_0005; exp_q.push_back(e);
        issue(TLB_OP_SRCH);
        csr_idx = 32'h0000_0007; s_found = 1'b0;
        e = ev0("srch_miss"); e.cwe = 4'b0001; e.idxv = 32'h8000_0007; exp_q.push_back(e);
        issue(TLB_OP_SRCH);

        // RD of a valid 4MB entry and of an invalid entry
        t = '0; t.e = 1'b1; t.vppn = 19'h00456; t.ps = 6'd21; t.g = 1'b1; t.asid = 10'h007;
        t.ppn0 = 20'hABCDE; t.plv0 = 2'd3; t.mat0 = 2'd1; t.d0 = 1'b1; t.v0 = 1'b1;
        t.ppn1 = 20'h12345; t.mat1 = 2'd2; t.v1 = 1'b1;
        tlb[4] = t;
        csr_idx = 32'h0000_0004; csr_asid = 32'h0000_0005;
        e = ev0("rd_hit"); e.cwe = 4'b1111; e.idxv = 32'h1500_0004; e.ehiv = 32'h008A_C000;
        e.elo0v = 32'h0ABC_DE5F; e.elo1v = 32'h0123_4561; e.asidv = 32'h0000_0007; exp_q.push_back(e);
        issue(TLB_OP_RD);
        csr_idx = 32'h0000_0009;
        e = ev0("rd_miss"); e.cwe = 4'b1111; e.idxv = 32'h8000_0009; exp_q.push_back(e);
        issue(TLB_OP_RD);

        // WR with NE=1: invalid unless in TLB refill
        csr_idx = 32'h8C00_0003; csr_ehi = 32'h0024_6000; csr_elo0 = 32'h0000_0143;
        csr_elo1 = 32'h0000_0241; csr_asid = 32'h0000_0005; csr_ecode = 6'h00;
        e = ev0("wr_ne"); e.we = 1'b1; e.idx = 4'd3; e.ent = wr_ent(1'b0, 6'd12); exp_q.push_back(e);
        issue(TLB_OP_WR);
        csr_ecode = 6'h3f;
        e = ev0("wr_tlbr"); e.we = 1'b1; e.idx = 4'd3; e.ent = wr_ent(1'b1, 6'd12); exp_q.push_back(e);
        issue(TLB_OP_WR);
        csr_ecode = 6'h00;

        // 17 FILLs walk the fill index
        csr_idx = 32'h0000_0000;
        lf = 8'h01;
        for (int k = 0; k < 17; k++) begin
            e = ev0("fill"); e.we = 1'b1; e.ent = wr_ent(1'b1, 6'd0);
`ifdef TLB_FILL_LFSR_EN
            e.idx = lf[3:0];
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
`else
            e.idx = 4'(k);
`endif
            exp_q.push_back(e);
            issue(TLB_OP_FILL);
        end

        // INV op=4 asid=5: only the non-global asid-5 entry goes
        for (int i = 0; i < N; i++) tlb[i] = '0;
        t = '0; t.e = 1'b1; t.g = 1'b0; t.asid = 10'h005; t.vppn = 19'h00111; t.ps = 6'd12; t.v0 = 1'b1;
        tlb[2] = t;
        t = '0; t.e = 1'b1; t.g = 1'b1; t.asid = 10'h005; t.vppn = 19'h00222; t.ps = 6'd12; t.v1 = 1'b1;
        tlb[7] = t;
        e = ev0("inv4_wr"); e.done = 1'b0; e.we = 1'b1; e.idx = 4'd2;
        t = tlb[2]; t.e = 1'b0; e.ent = t; exp_q.push_back(e);
        exp_q.push_back(ev0("inv4_done"));
        inv_op = 5'd4; inv_asid = 10'h005; inv_va = 32'h0;
        issue(TLB_OP_INV);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("inv4_busy_ready_done", 128'({op_ready, op_done}), 128'(0));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("inv4_done_cycle17", 128'(op_done), 128'(1));
        check("inv4_entry7_kept", 128'(tlb[7][88]), 128'(1));

        // INV op=6: 4MB entry matches on VPPN[18:9] only
        t = '0; t.e = 1'b1; t.g = 1'b1; t.asid = 10'h009; t.ps = 6'd21; t.vppn = 19'h12A5F;
        tlb[3] = t;
        t = '0; t.e = 1'b1; t.g = 1'b0; t.asid = 10'h005; t.ps = 6'd12; t.vppn = 19'h12A00;
        tlb[8] = t;
        e = ev0("inv6_wr"); e.done = 1'b0; e.we = 1'b1; e.idx = 4'd3;
        t = tlb[3]; t.e = 1'b0; e.ent = t; exp_q.push_back(e);
        exp_q.push_back(ev0("inv6_done"));
        inv_op = 5'd6; inv_asid = 10'h003; inv_va = {19'h12A00, 13'h0};
        issue(TLB_OP_INV);
        wait_done(40);
        check("inv6_entry8_kept", 128'(tlb[8][88]), 128'(1));

        // INV op=9: illegal, completes at once with no write
        e = ev0("inv9"); e.ine = 1'b1; exp_q.push_back(e);
        inv_op = 5'd9;
        issue(TLB_OP_INV);

        // INV op=0 interrupted by reset while sweeping entry 6
        for (int i = 0; i < N; i++) begin
            t = '0; t.e = 1'b1; t.asid = 10'(i); t.vppn = 19'(i); t.ps = 6'd12;
            tlb[i] = t;
            orig[i] = t;
        end
        for (int i = 0; i < 6; i++) begin
            e = ev0("inv0_wr"); e.done = 1'b0; e.we = 1'b1; e.idx = 4'(i);
            t = orig[i]; t.e = 1'b0; e.ent = t; exp_q.push_back(e);
        end
        inv_op = 5'd0;
        issue(TLB_OP_INV);
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_sweep_op_ready", 128'(op_ready), 128'(1));
        check("rst_sweep_we_done", 128'({we, op_done}), 128'(0));
        for (int i = 0; i < N; i++) begin
            if (i < 6) check("rst_sweep_invalidated", 128'(tlb[i][88]), 128'(0));
            else       check("rst_sweep_unchanged", 128'(tlb[i]), 128'(orig[i]));
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
